// File: rtl/action_engine.sv
`default_nettype none
// ============================================================================
// Module  : action_engine
// Brief   : Fetches 64-bit action primitives from SRAM and applies them to the
//           packet header; checksum hand-off enabled by ACTION_ENGINE_CKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module action_engine #(
    parameter int ADDR_W   = 32,
    parameter int HDR_BASE = 14,
    parameter int MAX_PRIM = 16,
    parameter int PORT_W   = 4,
    parameter int MCAST_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    output logic               mem_ce_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [3:0]         mem_width_o,
    output logic [31:0]        mem_data_o,
    input  logic [31:0]        mem_data_i,
    output logic               cksum_start_o,
    output logic [ADDR_W-1:0]  cksum_src_o,
    output logic [7:0]         cksum_len_o,
    output logic [ADDR_W-1:0]  cksum_dst_o,
    input  logic               cksum_ready_i,
    input  logic               cksum_mem_ce_i,
    input  logic               cksum_mem_we_i,
    input  logic [ADDR_W-1:0]  cksum_mem_addr_i,
    input  logic [3:0]         cksum_mem_width_i,
    input  logic [31:0]        cksum_mem_data_i,
    output logic               done_o,
    output logic               err_o,
    output logic [PORT_W-1:0]  port_o,
    output logic [MCAST_W-1:0] mcast_o,
    output logic               recirc_o
);

    localparam int C_CNT_W = $clog2(MAX_PRIM + 1);
`ifdef ACTION_ENGINE_CKSUM_EN
    localparam bit C_CKSUM_EN = 1'b1;
`else
    localparam bit C_CKSUM_EN = 1'b0;
`endif

    localparam logic [5:0] C_OP_NOP       = 6'd0;
    localparam logic [5:0] C_OP_CKSUM     = 6'd1;
    localparam logic [5:0] C_OP_ADD       = 6'd2;
    localparam logic [5:0] C_OP_COPY      = 6'd3;
    localparam logic [5:0] C_OP_SET       = 6'd4;
    localparam logic [5:0] C_OP_SET_PORT  = 6'd5;
    localparam logic [5:0] C_OP_SET_MCAST = 6'd6;
    localparam logic [5:0] C_OP_RECIRC    = 6'd7;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_F0  = 4'd1, S_F1  = 4'd2, S_F2   = 4'd3,
        S_EXEC = 4'd4, S_RD  = 4'd5, S_RDW = 4'd6, S_WR   = 4'd7,
        S_CK   = 4'd8, S_DONE = 4'd9, S_ERR = 4'd10
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [31:0]          hi_q, hi_d, lo_q, lo_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]          data_q, data_d;
    logic [PORT_W-1:0]    port_q, port_d;
    logic [MCAST_W-1:0]   mcast_q, mcast_d;
    logic                 recirc_q, recirc_d;
    logic [ADDR_W-1:0]    ck_src_q, ck_src_d, ck_dst_q, ck_dst_d;
    logic [7:0]           ck_len_q, ck_len_d;
    logic                 ck_req;

    // Primitive decode: the high word carries opcode/offsets/width, the low word imm.
    logic [5:0]        opcode;
    logic [1:0]        wcode;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] dst_addr, src_addr;
    logic [31:0]       wmask;
    logic [3:0]        wbytes;

    assign opcode   = hi_q[31:26];
    assign dst_addr = ADDR_W'(HDR_BASE) + ADDR_W'(hi_q[25:14]);
    assign src_addr = ADDR_W'(HDR_BASE) + ADDR_W'(hi_q[13:2]);
    assign wcode    = hi_q[1:0];
    assign imm      = lo_q;

    always_comb begin
        wmask  = 32'hFFFF_FFFF;
        wbytes = 4'd0;
        case (wcode)
            2'd0:    begin wmask = 32'h0000_00FF; wbytes = 4'd1; end
            2'd1:    begin wmask = 32'h0000_FFFF; wbytes = 4'd2; end
            2'd2:    begin wmask = 32'hFFFF_FFFF; wbytes = 4'd4; end
            default: begin wmask = 32'hFFFF_FFFF; wbytes = 4'd0; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        port_d      = port_q;
        mcast_d     = mcast_q;
        recirc_d    = recirc_q;
        ck_src_d    = ck_src_q;
        ck_len_d    = ck_len_q;
        ck_dst_d    = ck_dst_q;
        ck_req      = 1'b0;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_width_o = 4'd0;
        mem_data_o  = 32'd0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_F0;
                    pc_d     = start_addr_i;
                    cnt_d    = '0;
                    port_d   = '0;
                    mcast_d  = '0;
                    recirc_d = 1'b0;
                end
            end
            S_F0: begin
                if (cnt_q == C_CNT_W'(MAX_PRIM)) begin
                    state_d = S_ERR;
                end else begin
                    mem_ce_o    = 1'b1;
                    mem_addr_o  = pc_q;
                    mem_width_o = 4'd4;
                    state_d     = S_F1;
                end
            end
            S_F1: begin
                mem_ce_o    = 1'b1;
                mem_addr_o  = pc_q + ADDR_W'(4);
                mem_width_o = 4'd4;
                hi_d        = mem_data_i;
                state_d     = S_F2;
            end
            S_F2: begin
                lo_d    = mem_data_i;
                pc_d    = pc_q + ADDR_W'(8);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d = cnt_q + C_CNT_W'(1);
                // Only field-touching opcodes care about the width code.
                case (opcode)
                    C_OP_NOP:       state_d = S_DONE;
                    C_OP_CKSUM: begin
                        if (C_CKSUM_EN) begin
                            ck_src_d = src_addr;
                            ck_len_d = imm[7:0];
                            ck_dst_d = dst_addr;
                            state_d  = S_CK;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                    C_OP_ADD, C_OP_COPY: state_d = (wcode == 2'd3) ? S_ERR : S_RD;
                    C_OP_SET: begin
                        data_d  = imm & wmask;
                        state_d = (wcode == 2'd3) ? S_ERR : S_WR;
                    end
                    C_OP_SET_PORT:  begin port_d   = PORT_W'(imm);  state_d = S_F0; end
                    C_OP_SET_MCAST: begin mcast_d  = MCAST_W'(imm); state_d = S_F0; end
                    C_OP_RECIRC:    begin recirc_d = 1'b1;          state_d = S_F0; end
                    default:        state_d = S_ERR;
                endcase
            end
            S_RD: begin
                mem_ce_o    = 1'b1;
                mem_addr_o  = (opcode == C_OP_ADD) ? dst_addr : src_addr;
                mem_width_o = wbytes;
                state_d     = S_RDW;
            end
            S_RDW: begin
                data_d  = ((opcode == C_OP_ADD) ? (mem_data_i + imm) : mem_data_i) & wmask;
                state_d = S_WR;
            end
            S_WR: begin
                mem_ce_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = dst_addr;
                mem_width_o = wbytes;
                mem_data_o  = data_q;
                state_d     = S_F0;
            end
            S_CK: begin
                // Ready hands the SRAM port back combinationally in the same cycle.
                if (cksum_ready_i) begin
                    state_d = S_F0;
                end else begin
                    ck_req      = 1'b1;
                    mem_ce_o    = cksum_mem_ce_i;
                    mem_we_o    = cksum_mem_we_i;
                    mem_addr_o  = cksum_mem_addr_i;
                    mem_width_o = cksum_mem_width_i;
                    mem_data_o  = cksum_mem_data_i;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                if (!start_i) state_d = S_IDLE;
            end
            S_ERR: begin
                done_o = 1'b1;
                err_o  = 1'b1;
                if (!start_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            cnt_q    <= '0;
            data_q   <= 32'd0;
            port_q   <= '0;
            mcast_q  <= '0;
            recirc_q <= 1'b0;
            ck_src_q <= '0;
            ck_len_q <= 8'd0;
            ck_dst_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            port_q   <= port_d;
            mcast_q  <= mcast_d;
            recirc_q <= recirc_d;
            ck_src_q <= ck_src_d;
            ck_len_q <= ck_len_d;
            ck_dst_q <= ck_dst_d;
        end
    end

    assign port_o   = port_q;
    assign mcast_o  = mcast_q;
    assign recirc_o = recirc_q;

`ifdef ACTION_ENGINE_CKSUM_EN
    assign cksum_start_o = ck_req;
    assign cksum_src_o   = ck_src_q;
    assign cksum_len_o   = ck_len_q;
    assign cksum_dst_o   = ck_dst_q;
`else
    assign cksum_start_o = 1'b0;
    assign cksum_src_o   = '0;
    assign cksum_len_o   = 8'd0;
    assign cksum_dst_o   = '0;
    wire w_unused_ck = &{1'b0, ck_req, ck_src_q, ck_len_q, ck_dst_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_action_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_action_engine
// Brief   : Directed self-checking bench for action_engine with an SRAM model
//           and a write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_action_engine;
    localparam int ADDR_W   = 32;
    localparam int HDR_BASE = 14;
    localparam int MAX_PRIM = 16;
    localparam int PORT_W   = 4;
    localparam int MCAST_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start_i;
    logic [ADDR_W-1:0]  start_addr_i;
    logic               mem_ce_o, mem_we_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [3:0]         mem_width_o;
    logic [31:0]        mem_data_o, mem_data_i;
    logic               cksum_start_o;
    logic [ADDR_W-1:0]  cksum_src_o, cksum_dst_o;
    logic [7:0]         cksum_len_o;
    logic               cksum_ready_i;
    logic               cksum_mem_ce_i, cksum_mem_we_i;
    logic [ADDR_W-1:0]  cksum_mem_addr_i;
    logic [3:0]         cksum_mem_width_i;
    logic [31:0]        cksum_mem_data_i;
    logic               done_o, err_o, recirc_o;
    logic [PORT_W-1:0]  port_o;
    logic [MCAST_W-1:0] mcast_o;

    action_engine #(
        .ADDR_W(ADDR_W), .HDR_BASE(HDR_BASE), .MAX_PRIM(MAX_PRIM),
        .PORT_W(PORT_W), .MCAST_W(MCAST_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .cksum_start_o(cksum_start_o), .cksum_src_o(cksum_src_o),
        .cksum_len_o(cksum_len_o), .cksum_dst_o(cksum_dst_o),
        .cksum_ready_i(cksum_ready_i), .cksum_mem_ce_i(cksum_mem_ce_i),
        .cksum_mem_we_i(cksum_mem_we_i), .cksum_mem_addr_i(cksum_mem_addr_i),
        .cksum_mem_width_i(cksum_mem_width_i), .cksum_mem_data_i(cksum_mem_data_i),
        .done_o(done_o), .err_o(err_o), .port_o(port_o), .mcast_o(mcast_o),
        .recirc_o(recirc_o)
    );

    // Big-endian byte SRAM; read data registered one cycle after the address.
    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
    } wr_t;

    logic [7:0]  mem [0:1023];
    logic        ld_we, ld_byte;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] rdata_q;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    wire  [9:0]  sa = mem_addr_o[9:0];

    assign mem_data_i = rdata_q;

    function automatic logic [31:0] rd(input logic [9:0] a, input logic [3:0] w);
        case (w)
            4'd1:    return {24'd0, mem[a]};
            4'd2:    return {16'd0, mem[a], mem[a+10'd1]};
            default: return {mem[a], mem[a+10'd1], mem[a+10'd2], mem[a+10'd3]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (ld_we) begin
            if (ld_byte) begin
                mem[ld_addr] <= ld_data[7:0];
            end else begin
                mem[ld_addr]       <= ld_data[31:24];
                mem[ld_addr+10'd1] <= ld_data[23:16];
                mem[ld_addr+10'd2] <= ld_data[15:8];
                mem[ld_addr+10'd3] <= ld_data[7:0];
            end
        end else if (mem_ce_o && mem_we_o) begin
            obs_q.push_back(wr_t'({mem_addr_o, mem_width_o, mem_data_o}));
            case (mem_width_o)
                4'd1: mem[sa] <= mem_data_o[7:0];
                4'd2: begin
                    mem[sa]       <= mem_data_o[15:8];
                    mem[sa+10'd1] <= mem_data_o[7:0];
                end
                default: begin
                    mem[sa]       <= mem_data_o[31:24];
                    mem[sa+10'd1] <= mem_data_o[23:16];
                    mem[sa+10'd2] <= mem_data_o[15:8];
                    mem[sa+10'd3] <= mem_data_o[7:0];
                end
            endcase
        end else if (mem_ce_o) begin
            rdata_q <= rd(sa, mem_width_o);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d, input logic one_byte);
        ld_we = 1'b1; ld_byte = one_byte; ld_addr = a[9:0]; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    function automatic logic [63:0] prim(input logic [5:0] op, input logic [11:0] dst,
                                         input logic [11:0] src, input logic [1:0] w,
                                         input logic [31:0] imm);
        return {op, dst, src, w, imm};
    endfunction

    task automatic load_prim(input int a, input logic [63:0] p);
        poke(a, p[63:32], 1'b0);
        poke(a + 4, p[31:0], 1'b0);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        exp_q.push_back(wr_t'({a, w, d}));
    endtask

    task automatic begin_run(input logic [31:0] a);
        start_addr_i = a;
        start_i      = 1'b1;
        tick();
        chk("first fetch", 72'({mem_ce_o, mem_width_o, mem_addr_o}), 72'({1'b1, 4'd4, a}));
    endtask

    task automatic wait_done(input int budget, output int c);
        c = 0;
        while (done_o !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk("done reached", 72'(done_o), 72'(1));
    endtask

    task automatic end_run();
        start_i = 1'b0;
        tick();
        chk("back to idle", 72'({done_o, err_o, mem_ce_o, mem_width_o}), 72'(0));
    endtask

    task automatic check_writes(input string tag);
        wr_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " write present"}, 72'(obs_q.size() != 0), 72'(1));
            if (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                chk({tag, " write"}, 72'(o), 72'(e));
            end
        end
        chk({tag, " no extra writes"}, 72'(obs_q.size()), 72'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; start_addr_i = '0; cksum_ready_i = 1'b0;
        cksum_mem_ce_i = 1'b0; cksum_mem_we_i = 1'b0; cksum_mem_addr_i = '0;
        cksum_mem_width_i = 4'd0; cksum_mem_data_i = 32'd0;
        ld_we = 1'b0; ld_byte = 1'b0; ld_addr = '0; ld_data = 32'd0;
        repeat (3) tick();
        chk("reset outputs", 72'({done_o, err_o, mem_ce_o, mem_we_o, mem_width_o,
            cksum_start_o, port_o, mcast_o, recirc_o}), 72'(0));
        rst = 1'b0;
        tick();

        // SET 16-bit then NOP
        load_prim(32'h100, prim(6'd4, 12'd0, 12'd0, 2'd1, 32'h0000_ABCD));
        load_prim(32'h108, prim(6'd0, 12'd0, 12'd0, 2'd0, 32'd0));
        expect_wr(32'd14, 4'd2, 32'h0000_ABCD);
        begin_run(32'h100);
        wait_done(30, cyc);
        chk("set latency", 72'(cyc), 72'(9));
        chk("set err", 72'(err_o), 72'(0));
        end_run();
        check_writes("set");
        chk("set bytes", 72'({mem[14], mem[15]}), 72'(16'hABCD));

        // ADD wraps a byte field
        poke(22, 32'h0000_00FF, 1'b1);
        load_prim(32'h120, prim(6'd2, 12'd8, 12'd0, 2'd0, 32'd2));
        load_prim(32'h128, prim(6'd0, 12'd0, 12'd0, 2'd0, 32'd0));
        expect_wr(32'd22, 4'd1, 32'h0000_0001);
        begin_run(32'h120);
        wait_done(30, cyc);
        chk("add err", 72'(err_o), 72'(0));
        end_run();
        check_writes("add");
        chk("add byte", 72'(mem[22]), 72'(8'h01));

        // COPY word plus egress metadata
        poke(26, 32'hDEAD_BEEF, 1'b0);
        load_prim(32'h140, prim(6'd3, 12'd16, 12'd12, 2'd2, 32'd0));
        load_prim(32'h148, prim(6'd5, 12'd0, 12'd0, 2'd0, 32'd3));
        load_prim(32'h150, prim(6'd6, 12'd0, 12'd0, 2'd0, 32'h1234));
        load_prim(32'h158, prim(6'd7, 12'd0, 12'd0, 2'd0, 32'd0));
        load_prim(32'h160, prim(6'd0, 12'd0, 12'd0, 2'd0, 32'd0));
        expect_wr(32'd30, 4'd4, 32'hDEAD_BEEF);
        begin_run(32'h140);
        wait_done(60, cyc);
        chk("meta outputs", 72'({port_o, mcast_o, recirc_o, err_o}),
            72'({4'd3, 16'h1234, 1'b1, 1'b0}));
        end_run();
        chk("meta held", 72'({port_o, mcast_o, recirc_o}), 72'({4'd3, 16'h1234, 1'b1}));
        check_writes("copy");

        // CKSUM hand-off, then SET, then NOP
        load_prim(32'h180, prim(6'd1, 12'd10, 12'd2, 2'd0, 32'h14));
        load_prim(32'h188, prim(6'd4, 12'd20, 12'd0, 2'd0, 32'h5A));
        load_prim(32'h190, prim(6'd0, 12'd0, 12'd0, 2'd0, 32'd0));
`ifdef ACTION_ENGINE_CKSUM_EN
        expect_wr(32'd24, 4'd2, 32'h0000_BEEF);
        expect_wr(32'd34, 4'd1, 32'h0000_005A);
        begin_run(32'h180);
        cyc = 0;
        while (cksum_start_o !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("cksum start seen", 72'(cksum_start_o), 72'(1));
        chk("cksum fields", 72'({cksum_src_o, cksum_len_o, cksum_dst_o}),
            72'({32'd16, 8'h14, 32'd24}));
        tick();
        cksum_mem_ce_i = 1'b1; cksum_mem_we_i = 1'b1; cksum_mem_addr_i = cksum_dst_o;
        cksum_mem_width_i = 4'd2; cksum_mem_data_i = 32'h0000_BEEF;
        #1;
        chk("mux to cksum unit", 72'({mem_ce_o, mem_we_o, mem_addr_o, mem_width_o}),
            72'({1'b1, 1'b1, 32'd24, 4'd2}));
        tick();
        cksum_mem_ce_i = 1'b0; cksum_mem_we_i = 1'b0; cksum_mem_addr_i = '0;
        cksum_mem_width_i = 4'd0; cksum_mem_data_i = 32'd0;
        tick();
        tick();
        chk("cksum start held", 72'(cksum_start_o), 72'(1));
        tick();
        cksum_ready_i = 1'b1;
        #1;
        chk("cksum handback", 72'({cksum_start_o, mem_ce_o}), 72'(0));
        tick();
        cksum_ready_i = 1'b0;
        chk("next prim fetched", 72'({mem_ce_o, mem_we_o, mem_addr_o}),
            72'({1'b1, 1'b0, 32'h188}));
        wait_done(40, cyc);
        chk("cksum err", 72'(err_o), 72'(0));
        end_run();
        check_writes("cksum");
`else
        begin_run(32'h180);
        wait_done(20, cyc);
        chk("cksum disabled err", 72'({err_o, cksum_start_o}), 72'({1'b1, 1'b0}));
        chk("cksum outputs tied", 72'({cksum_src_o, cksum_len_o, cksum_dst_o}), 72'(0));
        end_run();
        check_writes("cksum off");
`endif

        // Unknown opcode
        load_prim(32'h1C0, prim(6'h3F, 12'd0, 12'd0, 2'd0, 32'h11));
        begin_run(32'h1C0);
        wait_done(20, cyc);
        chk("bad op latency", 72'(cyc), 72'(4));
        chk("bad op err", 72'({done_o, err_o, mem_ce_o, mem_width_o}), 72'({1'b1, 1'b1, 1'b0, 4'd0}));
        end_run();
        check_writes("bad op");

        // Width code 3
        load_prim(32'h1D0, prim(6'd4, 12'd0, 12'd0, 2'd3, 32'h22));
        begin_run(32'h1D0);
        wait_done(20, cyc);
        chk("bad width err", 72'({done_o, err_o}), 72'({1'b1, 1'b1}));
        end_run();
        check_writes("bad width");

        // MAX_PRIM+1 SETs with no NOP
        for (int k = 0; k <= MAX_PRIM; k++) begin
            load_prim(32'h200 + 8 * k, prim(6'd4, 12'(k), 12'd0, 2'd0, 32'h40 + k));
            if (k < MAX_PRIM) expect_wr(32'(HDR_BASE + k), 4'd1, 32'h40 + k);
        end
        begin_run(32'h200);
        wait_done(200, cyc);
        chk("limit err", 72'(err_o), 72'(1));
        end_run();
        check_writes("limit");

        // Reset in RDW aborts the run
        load_prim(32'h2A0, prim(6'd2, 12'd8, 12'd0, 2'd0, 32'd1));
        load_prim(32'h2A8, prim(6'd0, 12'd0, 12'd0, 2'd0, 32'd0));
        begin_run(32'h2A0);
        repeat (4) tick();
        chk("add read issued", 72'({mem_ce_o, mem_we_o, mem_addr_o, mem_width_o}),
            72'({1'b1, 1'b0, 32'd22, 4'd1}));
        tick();
        rst = 1'b1;
        tick();
        chk("rst mid-run", 72'({done_o, err_o, mem_ce_o, mem_we_o, mem_width_o,
            cksum_start_o, port_o, mcast_o, recirc_o}), 72'(0));
        rst = 1'b0;
        start_i = 1'b0;
        tick();
        expect_wr(32'd14, 4'd2, 32'h0000_ABCD);
        begin_run(32'h100);
        wait_done(30, cyc);
        chk("rerun latency", 72'(cyc), 72'(9));
        chk("rerun err", 72'(err_o), 72'(0));
        end_run();
        check_writes("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
